// File: rtl/csr_issue_queue.sv
// csr_issue_queue: age-ordered CSR issue queue with tag wakeup and a registered issue stage.
// Define CSR_IQ_BYPASS_EN to let a ready op skip the array when nothing older is ready.
module csr_issue_queue #(
  parameter int DEPTH     = 16,
  parameter int TAG_W     = 8,
  parameter int PAYLOAD_W = 121,
  parameter int NUM_WAKE  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      in_src_rdy,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [NUM_WAKE-1:0]       wake_valid,
  input  logic [NUM_WAKE*TAG_W-1:0] wake_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAG_W-1:0]          out_tag,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                      full,
  output logic                      empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]     valid_q, rdy_q, req, sel, wake_hit;
  logic [TAG_W-1:0]     tag_q [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q [DEPTH];
  logic [DEPTH-1:0]     age_q [DEPTH];
  logic [CW-1:0]        count_q;
  logic                 out_valid_q;
  logic [TAG_W-1:0]     out_tag_q;
  logic [PAYLOAD_W-1:0] out_payload_q;
  logic [IW-1:0]        sel_idx, free_idx;
  logic                 in_hit, load, issue, accept, bypass, alloc;

  always_comb begin
    in_hit = in_src_rdy;
    for (int c = 0; c < NUM_WAKE; c++)
      in_hit = in_hit | (wake_valid[c] && wake_tag[c*TAG_W +: TAG_W] == in_tag);
    wake_hit = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int c = 0; c < NUM_WAKE; c++)
        wake_hit[i] = wake_hit[i] | (wake_valid[c] && wake_tag[c*TAG_W +: TAG_W] == tag_q[i]);
    req = valid_q & rdy_q;
    // an entry is selected when no other ready entry is older than it
    sel = req;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (req[j] && age_q[j][i]) sel[i] = 1'b0;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel[i]) sel_idx = IW'(i);
    for (int i = DEPTH-1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IW'(i);
  end

  assign full        = count_q == CW'(DEPTH);
  assign empty       = count_q == '0;
  assign in_ready    = !full;
  assign count       = count_q;
  assign out_valid   = out_valid_q;
  assign out_tag     = out_tag_q;
  assign out_payload = out_payload_q;
  assign load        = !out_valid_q || out_ready;
  assign issue       = load && |req;
  assign accept      = in_valid && in_ready;
`ifdef CSR_IQ_BYPASS_EN
  assign bypass      = accept && in_hit && !(|req) && load;
`else
  assign bypass      = 1'b0;
`endif
  assign alloc       = accept && !bypass;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q       <= '0;
      rdy_q         <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      out_tag_q     <= '0;
      out_payload_q <= '0;
    end else begin
      rdy_q <= rdy_q | wake_hit;
      if (issue) valid_q[sel_idx] <= 1'b0;
      if (alloc) begin
        valid_q[free_idx] <= 1'b1;
        rdy_q[free_idx]   <= in_hit;
        tag_q[free_idx]   <= in_tag;
        pl_q[free_idx]    <= in_payload;
        for (int j = 0; j < DEPTH; j++) age_q[j][free_idx] <= 1'b1;
        age_q[free_idx] <= '0;
      end
      if (issue) begin
        out_valid_q   <= 1'b1;
        out_tag_q     <= tag_q[sel_idx];
        out_payload_q <= pl_q[sel_idx];
      end else if (bypass) begin
        out_valid_q   <= 1'b1;
        out_tag_q     <= in_tag;
        out_payload_q <= in_payload;
      end else if (out_ready) begin
        out_valid_q   <= 1'b0;
      end
      count_q <= count_q + CW'(alloc) - CW'(issue);
    end
  end
endmodule

// File: tb/tb_csr_issue_queue.sv
// tb_csr_issue_queue: directed checks of allocation, wakeup, age order, full, stall and flush.
module tb_csr_issue_queue;
  localparam int DEPTH = 16, TAG_W = 8, PW = 121, NW = 7, CW = $clog2(DEPTH+1);
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, in_src_rdy, out_valid, out_ready, full, empty;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [PW-1:0] in_payload, out_payload;
  logic [NW-1:0] wake_valid;
  logic [NW*TAG_W-1:0] wake_tag;
  logic [CW-1:0] count;
  int n_run = 0, n_fail = 0;

  csr_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW), .NUM_WAKE(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_src_rdy(in_src_rdy), .in_payload(in_payload),
    .wake_valid(wake_valid), .wake_tag(wake_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_payload(out_payload), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [7:0] t, input logic r, input logic [PW-1:0] p);
    in_valid = v; in_tag = t; in_src_rdy = r; in_payload = p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    wake_valid = '0; wake_tag = '0;
    put(0, 8'h00, 0, '0);
    step(); step();
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);

    // single ready op: two cycles to out_valid
    out_ready = 1'b1;
    put(1, 8'h05, 1, 121'h0abc);
    step();
    put(0, 8'h00, 0, '0);
    chk("t1_count_after_accept", count, 1);
    chk("t1_out_valid_early", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_tag", out_tag, 8'h05);
    chk("t1_out_payload", out_payload, 121'h0abc);
    chk("t1_count_back", count, 0);
    step();
    chk("t1_drain", out_valid, 0);

    // A not ready, B ready: B first, A after wakeup on channel 2
    put(1, 8'h10, 0, 121'hA);
    step();
    put(1, 8'h11, 1, 121'hB);
    step();
    put(0, 8'h00, 0, '0);
    chk("t2_count2", count, 2);
    step();
    chk("t2_b_first", out_tag, 8'h11);
    chk("t2_count1", count, 1);
    wake_valid = 7'b0000100; wake_tag[2*TAG_W +: TAG_W] = 8'h10;
    step();
    wake_valid = '0; wake_tag = '0;
    chk("t2_gap", out_valid, 0);
    step();
    chk("t2_a_valid", out_valid, 1);
    chk("t2_a_tag", out_tag, 8'h10);
    chk("t2_a_payload", out_payload, 121'hA);
    chk("t2_count0", count, 0);
    step();

    // same-cycle broadcast on channel 6 marks the op ready at insert
    put(1, 8'h20, 0, 121'h20);
    wake_valid = 7'b1000000; wake_tag[6*TAG_W +: TAG_W] = 8'h20;
    step();
    put(0, 8'h00, 0, '0);
    wake_valid = '0; wake_tag = '0;
    step();
    chk("t3_valid", out_valid, 1);
    chk("t3_tag", out_tag, 8'h20);
    step();
    chk("t3_drain", out_valid, 0);

    // fill with non-ready ops, 17th ignored, then wake and drain in age order
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      put(1, 8'h40, 0, PW'(32'h100 + i));
      step();
    end
    chk("t4_count16", count, 16);
    chk("t4_full", full, 1);
    chk("t4_in_ready", in_ready, 0);
    put(1, 8'h77, 1, 121'h177);
    step();
    chk("t4_17th_ignored", count, 16);
    wake_valid = 7'b0000001; wake_tag[TAG_W-1:0] = 8'h40;
    out_ready = 1'b1;
    step();
    wake_valid = '0; wake_tag = '0;
    chk("t4_still_full", count, 16);
    chk("t4_no_issue_yet", out_valid, 0);
    step();
    chk("t4_first_valid", out_valid, 1);
    chk("t4_first_payload", out_payload, 121'h100);
    chk("t4_count15", count, 15);
    chk("t4_in_ready_back", in_ready, 1);
    step();
    put(0, 8'h00, 0, '0);
    chk("t4_accept_and_issue", count, 15);
    chk("t4_second_payload", out_payload, 121'h101);
    for (int i = 2; i < DEPTH; i++) begin
      step();
      chk("t4_order", out_payload, PW'(32'h100 + i));
    end
    chk("t4_count1", count, 1);
    step();
    chk("t4_late_tag", out_tag, 8'h77);
    chk("t4_late_payload", out_payload, 121'h177);
    chk("t4_count0", count, 0);
    step();
    chk("t4_drain", out_valid, 0);

    // C, D, E with out_ready 1,0,1,1
    put(1, 8'hC0, 1, 121'hC);
    step();
    put(1, 8'hD0, 1, 121'hD);
    step();
    chk("t5_c", out_tag, 8'hC0);
    put(1, 8'hE0, 1, 121'hE);
    out_ready = 1'b0;
    step();
    put(0, 8'h00, 0, '0);
    chk("t5_stall_tag", out_tag, 8'hC0);
    chk("t5_stall_payload", out_payload, 121'hC);
    chk("t5_stall_count", count, 2);
    out_ready = 1'b1;
    step();
    chk("t5_d", out_tag, 8'hD0);
    step();
    chk("t5_e", out_tag, 8'hE0);
    chk("t5_e_payload", out_payload, 121'hE);
    step();
    chk("t5_drain", out_valid, 0);

    // flush with five queued and one held, plus a same-cycle dispatch
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(1, 8'(8'h60 + i), 1, PW'(32'h600 + i));
      step();
    end
    chk("t6_count5", count, 5);
    chk("t6_held", out_valid, 1);
    chk("t6_held_tag", out_tag, 8'h60);
    flush = 1'b1;
    put(1, 8'h99, 1, 121'h999);
    step();
    flush = 1'b0;
    put(0, 8'h00, 0, '0);
    chk("t6_count0", count, 0);
    chk("t6_out_valid0", out_valid, 0);
    chk("t6_empty", empty, 1);
    step();
    chk("t6_no_late_accept", count, 0);
    chk("t6_no_late_issue", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
